// File: rtl/glock_pkg.sv
// rtl/glock_pkg.sv - shared state encoding and index-width helper for the lock arbiter
package glock_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    HELD    = 2'd1,
    REVOKED = 2'd2
  } glock_state_t;

  // Bits needed to index n cores; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set-bit search from a pointer
module rr_pick
  import glock_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan offsets from farthest to nearest so the closest set bit at or after ptr wins.
  always_comb begin
    found = |req;
    idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/glock_arbiter.sv
// rtl/glock_arbiter.sv - round-robin lock owner and global memory port arbiter for N cores
module glock_arbiter
  import glock_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int CORE_W    = 1,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        need_lock,
  input  logic [NUM_CORES*ADDR_W-1:0] gaddress,
  input  logic [NUM_CORES*DATA_W-1:0] gdata,
  input  logic [NUM_CORES-1:0]        gwren,
  output logic [NUM_CORES-1:0]        lock,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_q,
  output logic [DATA_W-1:0]           gq,
  output logic                        owner_valid,
  output logic [CORE_W-1:0]           owner_id,
  output logic                        timeout_pulse
);

  glock_state_t      st, st_n;
  logic [CORE_W-1:0] owner, owner_n;
  logic [CORE_W-1:0] rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_n;
  logic              pulse_n;

  logic              g_found, w_found;
  logic [CORE_W-1:0] g_idx, w_idx, wsel, msel;

  logic [ADDR_W-1:0] addr_a [NUM_CORES];
  logic [DATA_W-1:0] data_a [NUM_CORES];

  // Next core index, wrapping so rr_ptr never leaves 0..NUM_CORES-1.
  function automatic logic [CORE_W-1:0] wrap_inc(input logic [CORE_W-1:0] i);
    return CORE_W'((int'(i) + 1) % NUM_CORES);
  endfunction

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slice
    assign addr_a[gi] = gaddress[gi*ADDR_W +: ADDR_W];
    assign data_a[gi] = gdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_CORES), .W(CORE_W)) u_grant_pick (
    .req   (need_lock),
    .ptr   (rr_ptr),
    .found (g_found),
    .idx   (g_idx)
  );

  rr_pick #(.N(NUM_CORES), .W(CORE_W)) u_write_pick (
    .req   (gwren),
    .ptr   (rr_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // The owner has the memory port while held; otherwise the round-robin writer does.
  assign wsel        = w_found ? w_idx : rr_ptr;
  assign msel        = (st == HELD) ? owner : wsel;
  assign mem_addr    = addr_a[msel];
  assign mem_data    = data_a[msel];
  assign mem_wren    = rst & gwren[msel];
  assign gq          = mem_q;
  assign owner_valid = (st == HELD);
  assign owner_id    = owner;

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= FREE;
      owner         <= '0;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      st            <= st_n;
      owner         <= owner_n;
      rr_ptr        <= rr_ptr_n;
      hold_cnt      <= hold_cnt_n;
      timeout_pulse <= pulse_n;
    end
  end

  // Grant, release and revoke decisions.
  always_comb begin
    st_n       = st;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    pulse_n    = 1'b0;
    case (st)
      FREE: begin
        if (w_found) rr_ptr_n = wrap_inc(w_idx);
        if (g_found) begin
          st_n       = HELD;
          owner_n    = g_idx;
          hold_cnt_n = '0;
        end
      end
      HELD: begin
        if (!need_lock[owner]) begin
          st_n     = FREE;
          rr_ptr_n = wrap_inc(owner);
        end else if (TIMEOUT != 0 && hold_cnt == CNT_W'(TIMEOUT - 1)) begin
          st_n     = REVOKED;
          pulse_n  = 1'b1;
          rr_ptr_n = wrap_inc(owner);
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      REVOKED: begin
        if (!need_lock[owner]) st_n = FREE;
      end
      default: st_n = FREE;
    endcase
  end

  // Per-core stall: waiting requesters, blocked writers and a revoked owner; cleared in reset.
  always_comb begin
    lock = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      lock[i] = (need_lock[i] && !(st == HELD && owner == CORE_W'(i)))
             || (st == HELD && owner != CORE_W'(i) && gwren[i])
             || (st == REVOKED && owner == CORE_W'(i))
             || (st != HELD && gwren[i] && wsel != CORE_W'(i));
    end
    if (!rst) lock = '0;
  end

endmodule

// File: tb/tb_glock_arbiter.sv
// tb/tb_glock_arbiter.sv - scoreboard bench for two-core, timeout and four-core arbiter builds
module tb_glock_arbiter;

  typedef struct {
    string       tag;
    logic [14:0] val;
    logic [14:0] mask;
  } exp_t;

  localparam logic [14:0] M_ALL    = 15'h7fff;
  localparam logic [14:0] M_NOADDR = 15'h607f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Two-core build, no timeout
  logic        a_rst;
  logic [1:0]  a_need, a_gwren, a_lock;
  logic [11:0] a_gaddr;
  logic [63:0] a_gdata;
  logic [31:0] a_mem_q, a_mdata, a_gq;
  logic [5:0]  a_maddr;
  logic        a_mwren, a_ov, a_pulse;
  logic [0:0]  a_oid;

  // Two-core build, TIMEOUT=4
  logic        t_rst;
  logic [1:0]  t_need, t_gwren, t_lock;
  logic [11:0] t_gaddr;
  logic [63:0] t_gdata;
  logic [31:0] t_mem_q, t_mdata, t_gq;
  logic [5:0]  t_maddr;
  logic        t_mwren, t_ov, t_pulse;
  logic [0:0]  t_oid;

  // Four-core build
  logic         f_rst;
  logic [3:0]   f_need, f_gwren, f_lock;
  logic [23:0]  f_gaddr;
  logic [127:0] f_gdata;
  logic [31:0]  f_mem_q, f_mdata, f_gq;
  logic [5:0]   f_maddr;
  logic         f_mwren, f_ov, f_pulse;
  logic [1:0]   f_oid;

  glock_arbiter #(.NUM_CORES(2), .CORE_W(1), .ADDR_W(6), .DATA_W(32), .TIMEOUT(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .need_lock(a_need), .gaddress(a_gaddr), .gdata(a_gdata),
    .gwren(a_gwren), .lock(a_lock), .mem_addr(a_maddr), .mem_data(a_mdata), .mem_wren(a_mwren),
    .mem_q(a_mem_q), .gq(a_gq), .owner_valid(a_ov), .owner_id(a_oid), .timeout_pulse(a_pulse)
  );

  glock_arbiter #(.NUM_CORES(2), .CORE_W(1), .ADDR_W(6), .DATA_W(32), .TIMEOUT(4), .CNT_W(16)) dut_t (
    .clk(clk), .rst(t_rst), .need_lock(t_need), .gaddress(t_gaddr), .gdata(t_gdata),
    .gwren(t_gwren), .lock(t_lock), .mem_addr(t_maddr), .mem_data(t_mdata), .mem_wren(t_mwren),
    .mem_q(t_mem_q), .gq(t_gq), .owner_valid(t_ov), .owner_id(t_oid), .timeout_pulse(t_pulse)
  );

  glock_arbiter #(.NUM_CORES(4), .CORE_W(2), .ADDR_W(6), .DATA_W(32), .TIMEOUT(0), .CNT_W(16)) dut_f (
    .clk(clk), .rst(f_rst), .need_lock(f_need), .gaddress(f_gaddr), .gdata(f_gdata),
    .gwren(f_gwren), .lock(f_lock), .mem_addr(f_maddr), .mem_data(f_mdata), .mem_wren(f_mwren),
    .mem_q(f_mem_q), .gq(f_gq), .owner_valid(f_ov), .owner_id(f_oid), .timeout_pulse(f_pulse)
  );

  function automatic logic [14:0] pk(input logic [3:0] lk, input logic ov, input logic [1:0] oid,
                                     input logic [5:0] ad, input logic wr, input logic pu);
    return {pu, wr, ad, oid, ov, lk};
  endfunction

  function automatic logic [14:0] obs_a();
    return pk({2'b00, a_lock}, a_ov, {1'b0, a_oid}, a_maddr, a_mwren, a_pulse);
  endfunction

  function automatic logic [14:0] obs_t();
    return pk({2'b00, t_lock}, t_ov, {1'b0, t_oid}, t_maddr, t_mwren, t_pulse);
  endfunction

  function automatic logic [14:0] obs_f();
    return pk(f_lock, f_ov, f_oid, f_maddr, f_mwren, f_pulse);
  endfunction

  task automatic pulse_reset_a();
    a_rst = 1'b0;
    @(posedge clk); #1;
    a_rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [14:0] got;
    a_rst = 1'b0; a_need = '0; a_gwren = '0; a_gaddr = {6'd22, 6'd11};
    sb.push_back('{tag:"reset", val:pk(4'b0000, 1'b0, 2'd0, 6'd11, 1'b0, 1'b0), mask:M_ALL});
    @(negedge clk);
    e = sb.pop_front(); got = obs_a(); n_cmp++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, got & e.mask, e.val & e.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_grant();
    exp_t e;
    logic [14:0] got;
    logic [1:0] nl [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic [3:0] lk [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic       ov [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] ad [4] = '{6'd11, 6'd11, 6'd11, 6'd22};
    pulse_reset_a();
    for (int i = 0; i < 4; i++) begin
      a_need = nl[i];
      sb.push_back('{tag:"grant", val:pk(lk[i], ov[i], 2'd0, ad[i], 1'b0, 1'b0), mask:M_ALL});
      @(negedge clk);
      e = sb.pop_front(); got = obs_a(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contend();
    exp_t e;
    logic [14:0] got;
    logic [1:0] nl  [5] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [3:0] lk  [5] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic       ov  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] oid [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [5:0] ad  [5] = '{6'd11, 6'd11, 6'd11, 6'd22, 6'd22};
    pulse_reset_a();
    for (int i = 0; i < 5; i++) begin
      a_need = nl[i];
      sb.push_back('{tag:"contend", val:pk(lk[i], ov[i], oid[i], ad[i], 1'b0, 1'b0), mask:M_ALL});
      @(negedge clk);
      e = sb.pop_front(); got = obs_a(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_stall();
    exp_t e;
    logic [14:0] got;
    logic [1:0] nl [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] wr [5] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
    logic [3:0] lk [5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic       ov [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] ad [5] = '{6'd22, 6'd22, 6'd22, 6'd22, 6'd5};
    logic       we [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    a_gaddr = {6'd22, 6'd5};
    for (int i = 0; i < 5; i++) begin
      a_need = nl[i]; a_gwren = wr[i];
      sb.push_back('{tag:"write_stall", val:pk(lk[i], ov[i], 2'd1, ad[i], we[i], 1'b0), mask:M_ALL});
      @(negedge clk);
      e = sb.pop_front(); got = obs_a(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_mux();
    exp_t e;
    logic [14:0] got;
    logic [1:0] wr [3] = '{2'b11, 2'b11, 2'b00};
    logic [3:0] lk [3] = '{4'b0010, 4'b0001, 4'b0000};
    logic [5:0] ad [3] = '{6'd3, 6'd7, 6'd3};
    logic       we [3] = '{1'b1, 1'b1, 1'b0};
    a_gaddr = {6'd7, 6'd3}; a_need = '0; a_mem_q = 32'hcafe_0123;
    for (int i = 0; i < 3; i++) begin
      a_gwren = wr[i];
      sb.push_back('{tag:"write_mux", val:pk(lk[i], 1'b0, 2'd1, ad[i], we[i], 1'b0), mask:M_ALL});
      @(negedge clk);
      e = sb.pop_front(); got = obs_a(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (a_gq !== 32'hcafe_0123) begin
      n_err++;
      $display("FAIL gq_broadcast: got %h expected %h", a_gq, 32'hcafe_0123);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [14:0] got;
    logic [1:0] nl  [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [3:0] lk  [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
    logic       ov  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] oid [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       pu  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_rst = 1'b0; t_need = '0; t_gwren = '0;
    @(posedge clk); #1;
    t_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t_need = nl[i];
      sb.push_back('{tag:"timeout", val:pk(lk[i], ov[i], oid[i], 6'd0, 1'b0, pu[i]), mask:M_NOADDR});
      @(negedge clk);
      e = sb.pop_front(); got = obs_t(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_four_core();
    exp_t e;
    logic [14:0] got;
    logic [3:0] nl  [12] = '{4'b0100, 4'b0100, 4'b0000, 4'b1101, 4'b1101, 4'b0101,
                             4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b1101};
    logic [3:0] lk  [12] = '{4'b0100, 4'b0000, 4'b0000, 4'b1101, 4'b0101, 4'b0101,
                             4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1001};
    logic       ov  [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] oid [12] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3,
                             2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    f_rst = 1'b0; f_need = '0; f_gwren = '0;
    @(posedge clk); #1;
    f_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      f_need = nl[i];
      sb.push_back('{tag:"four_core", val:pk(lk[i], ov[i], oid[i], 6'd0, 1'b0, 1'b0), mask:M_NOADDR});
      @(negedge clk);
      e = sb.pop_front(); got = obs_f(); n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", e.tag, i, got & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
    // Reset mid-hold with requests still raised, no clock edge before sampling.
    f_rst = 1'b0;
    sb.push_back('{tag:"async_reset", val:pk(4'b0000, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0), mask:M_NOADDR});
    @(negedge clk);
    e = sb.pop_front(); got = obs_f(); n_cmp++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, got & e.mask, e.val & e.mask);
    end
    @(posedge clk); #1;
    f_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b0; a_need = '0; a_gwren = '0; a_gaddr = '0; a_gdata = {32'h1111_2222, 32'h3333_4444}; a_mem_q = '0;
    t_rst = 1'b0; t_need = '0; t_gwren = '0; t_gaddr = '0; t_gdata = '0; t_mem_q = '0;
    f_rst = 1'b0; f_need = '0; f_gwren = '0; f_gaddr = '0; f_gdata = '0; f_mem_q = '0;
    test_reset();
    test_grant();
    test_contend();
    test_write_stall();
    test_write_mux();
    test_timeout();
    test_four_core();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glock_arbiter.md
Name: glock_arbiter

Overview:
- Parametrised lock and global-memory arbiter for an N-core tiny RISC-V cluster. It generalises the fixed two-core lock hookup.
- Each core drives need_lock (raised by the lock-request opcode, dropped by unlock) plus its global address, data and write enable.
- The block grants one lock owner at a time in round-robin order, stalls every other requester and muxes the single global memory port.
- An optional hold timeout forcibly revokes a lock that a core never releases.

Parameters:
- NUM_CORES, 2, number of cores; must be ≥2.
- CORE_W, 1, width of a core index; must satisfy 2**CORE_W ≥ NUM_CORES.
- ADDR_W, 6, global memory address width.
- DATA_W, 32, global memory data width.
- TIMEOUT, 0, maximum lock hold time in cycles; 0 disables the timeout.
- CNT_W, 16, hold counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- need_lock  in  NUM_CORES  per-core lock request, level
- gaddress  in  NUM_CORES*ADDR_W  per-core global address; core i occupies slice [i*ADDR_W +: ADDR_W]
- gdata  in  NUM_CORES*DATA_W  per-core write data, sliced the same way
- gwren  in  NUM_CORES  per-core write enable
- lock  out  NUM_CORES  per-core stall; 1 holds the core in its current state
- mem_addr  out  ADDR_W  global memory address
- mem_data  out  DATA_W  global memory write data
- mem_wren  out  1  global memory write enable
- mem_q  in  DATA_W  global memory read data
- gq  out  DATA_W  read data broadcast to all cores; equals mem_q
- owner_valid  out  1  a lock is currently held
- owner_id  out  CORE_W  index of the lock holder
- timeout_pulse  out  1  one-cycle pulse when a lock is revoked

Behaviour:
- Registered state: st, owner, rr_ptr, hold_cnt, timeout_pulse. Reset values: st=FREE, owner=0, rr_ptr=0, hold_cnt=0, timeout_pulse=0. Consequently owner_valid=0, owner_id=0, mem_wren=0 and lock is all zero.
- FSM states: FREE, HELD, REVOKED.
- FREE:
  - If any need_lock bit is set, pick the first requester at or after rr_ptr (wrapping modulo NUM_CORES) and register it as owner.
  - Go to HELD and clear hold_cnt.
  - The grant appears one cycle after need_lock is seen.
- HELD:
  - If need_lock[owner]=0: go to FREE and set rr_ptr=(owner+1) mod NUM_CORES.
  - Else if TIMEOUT≠0 and hold_cnt==TIMEOUT-1: go to REVOKED, pulse timeout_pulse for one cycle, set rr_ptr=owner+1.
  - Otherwise increment hold_cnt.
- REVOKED: the revoked core stays stalled until its need_lock drops; on that cycle go to FREE. Other requesters are not granted while in REVOKED.
- owner_valid is 1 in HELD only.
- lock[i] (combinational from registers and inputs) is 1 when any of these hold:
  - need_lock[i]=1 and not (HELD and owner==i);
  - HELD, owner≠i and gwren[i]=1;
  - REVOKED and owner==i.
- Memory mux:
  - In HELD, the port carries the owner's address, data and wren.
  - Otherwise it carries core wsel's signals, where wsel is the first core at or after rr_ptr with gwren=1 (core rr_ptr if none has gwren set).
  - Unselected cores with gwren=1 get lock=1.
  - In FREE, a core whose write is granted advances rr_ptr past it.
- Requests are level-sensitive.
  - A request that drops before it is granted is forgotten.
  - Simultaneous release by the owner and a request from another core: release takes effect this cycle and the grant follows next cycle (one FREE cycle minimum between owners).
- Indices wrap modulo NUM_CORES. rr_ptr must never hold a value ≥ NUM_CORES.
- Reset asserted mid-hold returns everything to reset values immediately; no pulse is emitted.

Decomposition:
- Shared package glock_pkg holds the state encodings (FREE=2'd0, HELD=2'd1, REVOKED=2'd2) and the index-width helper function.
- One sub-module, rr_pick: a combinational round-robin first-set-bit search of a NUM_CORES-bit vector starting from a pointer. It returns found and index, and is instantiated twice (lock grant and write select).

Test Plan:
- Reset, then need_lock=2'b01:
  - next cycle owner_valid=1, owner_id=0, lock=2'b00;
  - drop need_lock: owner_valid=0 on the next cycle and rr_ptr=1.
- Both cores raise need_lock in the same cycle with rr_ptr=0:
  - core 0 is granted, lock=2'b10;
  - core 0 releases: core 1 is granted two cycles later, lock=2'b00.
- Core 1 holds the lock and core 0 pulses gwren with gaddress=6'd5:
  - lock[0]=1;
  - mem_addr follows core 1's address;
  - mem_wren is 0 unless core 1 writes.
- No owner, both cores gwren=1 with addresses 3 and 7, rr_ptr=0:
  - cycle 1: mem_addr=3, lock=2'b10;
  - cycle 2: mem_addr=7.
- TIMEOUT=4, core 0 holds the lock continuously:
  - timeout_pulse=1 exactly 4 cycles after the grant;
  - then lock[0]=1 until need_lock[0] drops;
  - core 1 is granted afterwards.
- NUM_CORES=4 with requesters {0,2,3} and rr_ptr=3:
  - grant order 3, 0, 2;
  - reset asserted mid-hold forces owner_valid=0 and lock=4'b0 asynchronously.
